// File: rtl/cpu_pkg.sv
// Shared opcode encodings, instruction classes, sequencer states and the
// strobe bundle for the 16-register CPU control unit.
package cpu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_ADD = OP_ADD;

   typedef enum logic [3:0] {
      RESET, F0, F1, F2, T3, T4, T5, T6, T7, HALT
   } state_e;

   typedef enum logic [3:0] {
      CL_ALU3, CL_IMM, CL_MULDIV, CL_UNARY, CL_LD, CL_LDI, CL_ST, CL_BR,
      CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
   } iclass_e;

   typedef struct packed {
      logic pc_out;  logic mdr_out; logic zhigh_out; logic zlow_out;
      logic hi_out;  logic lo_out;  logic c_out;     logic inport_out;
      logic pc_in;   logic mar_in;  logic mdr_in;    logic ir_in;
      logic y_in;    logic z_in;    logic hi_in;     logic lo_in;
      logic con_in;  logic outport_in;
      logic inc_pc;  logic read;    logic write;
      logic gra;     logic grb;     logic grc;
      logic r_in;    logic r_out;   logic ba_out;
   } ctrl_t;

endpackage

// File: rtl/instr_class_decode.sv
// Maps an opcode to its instruction class and the final execute step, so the
// next-state and output decoders agree on instruction length.
module instr_class_decode
   import cpu_pkg::*;
(
   input  logic [4:0] opcode_i,
   output iclass_e    iclass_o,
   output state_e     last_step_o
);

   always_comb begin
      iclass_o = CL_NOP;
      case (opcode_i) inside
         OP_LD:              iclass_o = CL_LD;
         OP_LDI:             iclass_o = CL_LDI;
         OP_ST:              iclass_o = CL_ST;
         [OP_ADD:OP_ROL]:    iclass_o = CL_ALU3;
         [OP_ADDI:OP_ORI]:   iclass_o = CL_IMM;
         OP_MUL, OP_DIV:     iclass_o = CL_MULDIV;
         OP_NEG, OP_NOT:     iclass_o = CL_UNARY;
         OP_BR:              iclass_o = CL_BR;
         OP_JR:              iclass_o = CL_JR;
         OP_JAL:             iclass_o = CL_JAL;
         OP_IN:              iclass_o = CL_IN;
         OP_OUT:             iclass_o = CL_OUT;
         OP_MFHI:            iclass_o = CL_MFHI;
         OP_MFLO:            iclass_o = CL_MFLO;
         OP_HALT:            iclass_o = CL_HALT;
         default:            iclass_o = CL_NOP;
      endcase
   end

   // F2 as last step means the instruction has no execute phase.
   always_comb begin
      last_step_o = F2;
      case (iclass_o)
         CL_ALU3, CL_IMM, CL_LDI:             last_step_o = T5;
         CL_MULDIV, CL_BR:                    last_step_o = T6;
         CL_UNARY, CL_JAL:                    last_step_o = T4;
         CL_LD, CL_ST:                        last_step_o = T7;
         CL_JR, CL_IN, CL_OUT, CL_MFHI,
         CL_MFLO:                             last_step_o = T3;
         default:                             last_step_o = F2;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit: fetch F0-F2, per-opcode execute T3-T7, and all datapath
// strobes decoded from state, live IR and CON_FF.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int OPW  = 5,
   parameter int ALUW = 5
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [31:0]     IR,
   input  logic            CON_FF,
   input  logic            stop,
   output logic            PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout,
   output logic            PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin,
   output logic            IncPC, Read, Write,
   output logic            Gra, Grb, Grc, Rin, Rout, BAout,
   output logic [ALUW-1:0] alu_op,
   output logic            run,
   output state_e          state_o
);

   state_e            state_q, state_d, boundary_st, last_step;
   iclass_e           iclass;
   logic [OPW-1:0]    opcode;
   logic              unused_ir;
   ctrl_t             c;
   logic [ALUW-1:0]   alu_d;

   assign opcode    = IR[31 -: OPW];
   assign unused_ir = ^IR[31-OPW:0];

   instr_class_decode u_decode (
      .opcode_i    (opcode),
      .iclass_o    (iclass),
      .last_step_o (last_step)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= RESET;
      else          state_q <= state_d;
   end

   // The >= test also retires the instruction if a live IR change shortens it.
   always_comb begin
      boundary_st = stop ? HALT : F0;
      state_d     = state_q;
      case (state_q)
         RESET:   state_d = F0;
         F0:      state_d = F1;
         F1:      state_d = F2;
         F2:      state_d = (iclass == CL_HALT) ? HALT :
                            (last_step == F2) ? boundary_st : T3;
         T3:      state_d = (T3 >= last_step) ? boundary_st : T4;
         T4:      state_d = (T4 >= last_step) ? boundary_st : T5;
         T5:      state_d = (T5 >= last_step) ? boundary_st : T6;
         T6:      state_d = (T6 >= last_step) ? boundary_st : T7;
         T7:      state_d = boundary_st;
         HALT:    state_d = HALT;
         default: state_d = RESET;
      endcase
   end

   always_comb begin
      c     = '0;
      alu_d = '0;
      case (state_q)
         F0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1; end
         F1: begin c.zlow_out = 1'b1; c.pc_in = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; end
         F2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
         T3: case (iclass)
            CL_ALU3, CL_IMM:     begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            CL_MULDIV:           begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
            CL_UNARY:            begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(opcode); end
            CL_LD, CL_LDI, CL_ST: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1; end
            CL_BR:               begin c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1; end
            CL_JR:               begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            CL_JAL:              begin c.pc_out = 1'b1; c.grb = 1'b1; c.r_in = 1'b1; end
            CL_IN:               begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_OUT:              begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_in = 1'b1; end
            CL_MFHI:             begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_MFLO:             begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            default: ;
         endcase
         T4: case (iclass)
            CL_ALU3:             begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(opcode); end
            CL_IMM:              begin c.c_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(opcode); end
            CL_MULDIV:           begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(opcode); end
            CL_UNARY:            begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_LD, CL_LDI, CL_ST: begin c.c_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(ALU_ADD); end
            CL_BR:               begin c.pc_out = 1'b1; c.y_in = 1'b1; end
            CL_JAL:              begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1; end
            default: ;
         endcase
         T5: case (iclass)
            CL_ALU3, CL_IMM, CL_LDI: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_MULDIV:           begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
            CL_LD, CL_ST:        begin c.zlow_out = 1'b1; c.mar_in = 1'b1; end
            CL_BR:               begin c.c_out = 1'b1; c.z_in = 1'b1; alu_d = ALUW'(ALU_ADD); end
            default: ;
         endcase
         T6: case (iclass)
            CL_MULDIV:           begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
            CL_LD:               begin c.read = 1'b1; c.mdr_in = 1'b1; end
            CL_ST:               begin c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1; end
            CL_BR:               begin c.zlow_out = 1'b1; c.pc_in = CON_FF; end
            default: ;
         endcase
         T7: case (iclass)
            CL_LD:               begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
            CL_ST:               c.write = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

   assign {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout} =
          {c.pc_out, c.mdr_out, c.zhigh_out, c.zlow_out, c.hi_out, c.lo_out, c.c_out, c.inport_out};
   assign {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin} =
          {c.pc_in, c.mar_in, c.mdr_in, c.ir_in, c.y_in, c.z_in, c.hi_in, c.lo_in, c.con_in, c.outport_in};
   assign {IncPC, Read, Write} = {c.inc_pc, c.read, c.write};
   assign {Gra, Grb, Grc, Rin, Rout, BAout} = {c.gra, c.grb, c.grc, c.r_in, c.r_out, c.ba_out};
   assign alu_op  = alu_d;
   assign run     = (state_q != RESET) && (state_q != HALT);
   assign state_o = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch and several instruction
// classes, stop/halt handling and mid-instruction reset.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [31:0] IR;
  logic        CON_FF;
  logic        stop;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout;
  logic PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin;
  logic IncPC, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       run;
  state_e     state_o;

  int n_chk  = 0;
  int n_fail = 0;
  int write_cnt = 0;

  localparam logic [26:0] M_PCOUT = 27'd1 << 0,  M_MDROUT = 27'd1 << 1,  M_ZHI   = 27'd1 << 2;
  localparam logic [26:0] M_ZLO   = 27'd1 << 3,  M_HIOUT  = 27'd1 << 4,  M_LOOUT = 27'd1 << 5;
  localparam logic [26:0] M_COUT  = 27'd1 << 6,  M_INP    = 27'd1 << 7,  M_PCIN  = 27'd1 << 8;
  localparam logic [26:0] M_MARIN = 27'd1 << 9,  M_MDRIN  = 27'd1 << 10, M_IRIN  = 27'd1 << 11;
  localparam logic [26:0] M_YIN   = 27'd1 << 12, M_ZIN    = 27'd1 << 13, M_HIIN  = 27'd1 << 14;
  localparam logic [26:0] M_LOIN  = 27'd1 << 15, M_CONIN  = 27'd1 << 16, M_OUTP  = 27'd1 << 17;
  localparam logic [26:0] M_INCPC = 27'd1 << 18, M_READ   = 27'd1 << 19, M_WRITE = 27'd1 << 20;
  localparam logic [26:0] M_GRA   = 27'd1 << 21, M_GRB    = 27'd1 << 22, M_GRC   = 27'd1 << 23;
  localparam logic [26:0] M_RIN   = 27'd1 << 24, M_ROUT   = 27'd1 << 25, M_BAOUT = 27'd1 << 26;
  localparam logic [26:0] NONE    = 27'd0;

  logic [26:0] act_s;
  assign act_s = {BAout, Rout, Rin, Grc, Grb, Gra, Write, Read, IncPC, OutPortin, CONin,
                  LOin, HIin, Zin, Yin, IRin, MDRin, MARin, PCin, InPortout, Cout, LOout,
                  HIout, Zlowout, Zhighout, MDRout, PCout};

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .IR(IR), .CON_FF(CON_FF), .stop(stop),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .InPortout(InPortout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OutPortin(OutPortin),
    .IncPC(IncPC), .Read(Read), .Write(Write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run), .state_o(state_o)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(negedge clock) if (Write) write_cnt++;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [26:0] es, input logic [4:0] ea, input logic er);
    n_chk++;
    assert ({run, alu_op, act_s} === {er, ea, es}) else begin
      n_fail++;
      $error("FAIL %s: observed run=%b alu=%b strobes=%h, expected run=%b alu=%b strobes=%h",
             tag, run, alu_op, act_s, er, ea, es);
    end
  endtask

  task automatic chk_state(input string tag, input state_e es);
    n_chk++;
    assert (state_o === es) else begin
      n_fail++;
      $error("FAIL %s: observed state=%0d, expected state=%0d", tag, state_o, es);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // Checks F0, F1, F2 starting in F0; returns one cycle after F2.
  task automatic fetch(input string tag);
    chk({tag, "_f0"}, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b1);
    cyc();
    chk({tag, "_f1"}, M_ZLO | M_PCIN | M_READ | M_MDRIN, 5'b0, 1'b1);
    cyc();
    chk({tag, "_f2"}, M_MDROUT | M_IRIN, 5'b0, 1'b1);
    cyc();
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    #1;
    chk("rst_pulse_low", NONE, 5'b0, 1'b0);
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    reset_n = 1'b1; IR = 32'h0; CON_FF = 1'b0; stop = 1'b0;
    #2;
    // 1: reset held for three cycles, F0 one cycle after release
    reset_n = 1'b0;
    #1;
    chk("reset_async", NONE, 5'b0, 1'b0);
    chk_state("reset_state", RESET);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("reset_hold", NONE, 5'b0, 1'b0);
    end
    reset_n = 1'b1;
    cyc();
    chk_state("post_reset_f0", F0);

    // 2: add R1,R2,R3
    IR = 32'h1891_8000;
    fetch("add");
    chk("add_t3", M_GRB | M_ROUT | M_YIN, 5'b0, 1'b1);
    cyc();
    chk("add_t4", M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1);
    cyc();
    chk("add_t5", M_ZLO | M_GRA | M_RIN, 5'b0, 1'b1);
    cyc();
    chk_state("add_next_f0", F0);

    // 3: ld
    IR = 32'h0088_0005;
    fetch("ld");
    chk("ld_t3", M_GRB | M_BAOUT | M_YIN, 5'b0, 1'b1);
    cyc();
    chk("ld_t4", M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc();
    chk("ld_t5", M_ZLO | M_MARIN, 5'b0, 1'b1);
    cyc();
    chk("ld_t6", M_READ | M_MDRIN, 5'b0, 1'b1);
    cyc();
    chk("ld_t7", M_MDROUT | M_GRA | M_RIN, 5'b0, 1'b1);
    cyc();
    chk_state("ld_next_f0", F0);

    // addi: ALU op is the opcode itself, not ADD
    IR = 32'h6000_0000;
    fetch("addi");
    cyc();
    chk("addi_t4", M_COUT | M_ZIN, 5'b01100, 1'b1);
    cyc(); cyc();
    chk_state("addi_next_f0", F0);

    // 4: br taken then not taken
    IR = 32'h9800_0000;
    CON_FF = 1'b1;
    fetch("br1");
    chk("br1_t3", M_GRA | M_ROUT | M_CONIN, 5'b0, 1'b1);
    cyc();
    chk("br1_t4", M_PCOUT | M_YIN, 5'b0, 1'b1);
    cyc();
    chk("br1_t5", M_COUT | M_ZIN, 5'b00011, 1'b1);
    cyc();
    chk("br1_t6", M_ZLO | M_PCIN, 5'b0, 1'b1);
    cyc();
    CON_FF = 1'b0;
    fetch("br0");
    cyc(); cyc(); cyc();
    chk("br0_t6", M_ZLO, 5'b0, 1'b1);
    cyc();
    chk_state("br0_next_f0", F0);

    // mul: HI load in T6
    IR = 32'h7800_0000;
    fetch("mul");
    chk("mul_t3", M_GRA | M_ROUT | M_YIN, 5'b0, 1'b1);
    cyc(); cyc();
    chk("mul_t5", M_ZLO | M_LOIN, 5'b0, 1'b1);
    cyc();
    chk("mul_t6", M_ZHI | M_HIIN, 5'b0, 1'b1);
    cyc();

    // mfhi, jal, nop
    IR = 32'hC000_0000;
    fetch("mfhi");
    chk("mfhi_t3", M_HIOUT | M_GRA | M_RIN, 5'b0, 1'b1);
    cyc();
    IR = 32'hA800_0000;
    fetch("jal");
    chk("jal_t3", M_PCOUT | M_GRB | M_RIN, 5'b0, 1'b1);
    cyc();
    chk("jal_t4", M_GRA | M_ROUT | M_PCIN, 5'b0, 1'b1);
    cyc();
    IR = 32'hD000_0000;
    fetch("nop");
    chk_state("nop_next_f0", F0);

    // full st asserts Write at T7
    IR = 32'h1000_0000;
    fetch("st");
    cyc(); cyc(); cyc();
    chk("st_t6", M_GRA | M_ROUT | M_MDRIN, 5'b0, 1'b1);
    cyc();
    chk("st_t7", M_WRITE, 5'b0, 1'b1);
    cyc();
    chk_state("st_next_f0", F0);

    // 5: st aborted by reset during T6
    write_cnt = 0;
    fetch("sta");
    cyc(); cyc(); cyc();
    chk_state("sta_t6", T6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("sta_abort", NONE, 5'b0, 1'b0);
    chk_state("sta_abort_state", RESET);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk_state("sta_after_f0", F0);
    cyc(); cyc();
    chk_int("sta_no_write", write_cnt, 0);

    // 6: stop during add T5 -> HALT
    reset_pulse();
    IR = 32'h1891_8000;
    fetch("adds");
    cyc(); cyc();
    stop = 1'b1;
    #1;
    chk("adds_t5", M_ZLO | M_GRA | M_RIN, 5'b0, 1'b1);
    cyc();
    stop = 1'b0;
    chk_state("adds_halt", HALT);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("halt_hold", NONE, 5'b0, 1'b0);
    end
    chk_state("halt_still", HALT);
    reset_pulse();
    chk_state("halt_exit_f0", F0);

    // halt opcode
    IR = 32'hD800_0000;
    fetch("hlt");
    chk_state("hlt_halt", HALT);
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hlt_hold", NONE, 5'b0, 1'b0);
    end
    reset_pulse();
    chk("hlt_exit_f0", M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Moore-style control unit for the 16-register CPU. It fetches each instruction, steps through per-opcode execute steps T3..T7, and drives every datapath strobe. Its outputs include Gra/Grb/Grc/Rin/Rout/BAout, which feed the register select/encode logic directly downstream. Opcode is IR[31:27].

Parameters:
OPW, 5, opcode field width (IR[31:27])
ALUW, 5, width of alu_op output

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
IR  in  32  current instruction register contents
CON_FF  in  1  registered branch-condition flag from the datapath
stop  in  1  halt request, honoured at instruction boundary
PCout, MDRout, Zhighout, Zlowout, HIout, LOout, Cout, InPortout  out  1 each  bus-drive strobes
PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortin  out  1 each  register-load strobes
IncPC, Read, Write  out  1 each  PC+1 select, memory read, memory write
Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  to register select/encode
alu_op  out  ALUW  ALU operation; equals opcode encoding; ADD=00011
run  out  1  high except in RESET and HALT

Behaviour:
- State register is the only storage; outputs decode from state, IR and CON_FF only (no input-to-output path from stop).
- reset_n low, at any time including mid-instruction: state = RESET immediately; all outputs 0, alu_op = 0, run = 0. An aborted st never asserts Write.
- RESET goes to F0 on the first clock edge after reset release.
- Fetch:
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read, MDRin.
  - F2: MDRout, IRin.
  - F2 then goes to T3, or to the instruction boundary for nop.
- Execute steps, one clock each, with strobes not listed held at 0. "ALU" means alu_op = opcode; "ADD" means alu_op = 00011.
  - add/sub/and/or/shr/shra/shl/ror/rol (00011-01011): T3 Grb,Rout,Yin; T4 Grc,Rout,ALU,Zin; T5 Zlowout,Gra,Rin.
  - addi/andi/ori (01100-01110): T3 Grb,Rout,Yin; T4 Cout,ALU,Zin; T5 Zlowout,Gra,Rin.
  - mul/div (01111,10000): T3 Gra,Rout,Yin; T4 Grb,Rout,ALU,Zin; T5 Zlowout,LOin; T6 Zhighout,HIin.
  - neg/not (10001,10010): T3 Grb,Rout,ALU,Zin; T4 Zlowout,Gra,Rin.
  - ld (00000): T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
  - ldi (00001): T3 Grb,BAout,Yin; T4 Cout,ADD,Zin; T5 Zlowout,Gra,Rin.
  - st (00010): T3-T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 Write.
  - br (10011): T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,ADD,Zin; T6 Zlowout, with PCin = CON_FF.
  - jr (10100): T3 Gra,Rout,PCin.
  - jal (10101): T3 PCout,Grb,Rin; T4 Gra,Rout,PCin.
  - in/out/mfhi/mflo (10110-11001): one step, T3, each:
    - in: InPortout,Gra,Rin.
    - out: Gra,Rout,OutPortin.
    - mfhi: HIout,Gra,Rin.
    - mflo: LOout,Gra,Rin.
  - nop (11010) and undefined opcodes (11100-11111): no execute steps.
  - halt (11011): after F2 go to HALT.
- Instruction boundary (the last step of any instruction): next state is HALT if stop=1, otherwise F0.
- HALT is absorbing, with all strobes 0 and run = 0; only reset_n exits it.
- IR changes during execute are the datapath's concern; decode uses the live IR. IR is only loaded in F2.

Decomposition:
- cpu_pkg: opcode localparams (LD..HALT), ALU_ADD, and the state enumeration (RESET, F0-F2, T3-T7, HALT).
- One natural combinational sub-module, instr_class_decode: maps opcode to instruction class and last-step index. It is shared by next-state logic and output decode.

Test Plan:
1. reset_n low for 3 cycles, then high, with IR=0 -> all outputs 0 and run=0 during reset; F0 strobes (PCout,MARin,IncPC,Zin) appear one cycle after release.
2. IR=0x18918000 (add R1,R2,R3) -> F0..F2 then T3 Grb,Rout,Yin; T4 Grc,Rout,alu_op=00011,Zin; T5 Zlowout,Gra,Rin; F0 on the 7th cycle.
3. ld, opcode 00000 -> T3 BAout=1 and Rout=0; T6 Read,MDRin; T7 MDRout,Gra,Rin; total 8 cycles.
4. br (10011), first with CON_FF=1 then with CON_FF=0 -> T6 PCin=1 in the first case and PCin=0 in the second; Zlowout=1 in both.
5. st, with reset_n pulsed low during T6 -> Write never asserted; state RESET; F0 follows after release.
6. stop=1 during an add's T5 -> HALT next, run=0, strobes 0 for 10+ cycles. A halt opcode does the same after F2; only reset_n recovers.
